pipeline_ifid: RTL
==================

Name: pipeline_ifid

Overview:
- IF/ID pipeline register, directly downstream of the instruction fetch stage.
- Captures the instruction returned by an instruction memory with a ready handshake, together with the fetch PC and PC+4. Presents them to the decode stage.
- Applies hazard stalls and branch flushes, and inserts bubbles while instruction memory is not ready.
- A three-state FSM discards wrong-path fetch responses. Saturating counters record stall and flush events for simulation statistics.

Parameters:
WIDTH, 32, data/address width of instr, pc and pcplus4
CNTW, 16, width of the saturating event counters
NOP, 32'h00000000, bubble instruction word (sll $0,$0,0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
hazard  in  1  decode-stage load-use stall; hold the ID registers
pcsrc  in  1  branch taken; flush the ID registers
if_pc  in  WIDTH  PC of the current fetch
if_pcplus4  in  WIDTH  PC+4 from the fetch stage
imem_rdata  in  WIDTH  instruction memory read data
imem_ready  in  1  imem_rdata is valid this cycle
id_instr  out  WIDTH  instruction to decode
id_pc  out  WIDTH  PC of id_instr
id_pcplus4  out  WIDTH  PC+4 of id_instr
id_valid  out  1  id_instr is a real instruction, not a bubble
pc_hold  out  1  fetch stage must not advance PC (combinational)
fsm_state  out  2  0=RUN, 1=WAIT, 2=DROP
stall_count  out  CNTW  saturating count of hazard-hold cycles
flush_count  out  CNTW  saturating count of flush cycles

Behaviour:
- Reset (asynchronous, any cycle, including mid-wait):
  - id_instr=NOP, id_pc=0, id_pcplus4=0, id_valid=0.
  - State RUN; both counters 0.
- Bubble load: id_instr=NOP, id_valid=0, id_pc and id_pcplus4 unchanged.
- Capture: id_instr=imem_rdata, id_pc=if_pc, id_pcplus4=if_pcplus4, id_valid=1.
- Capture latency: 1 cycle, from the cycle imem_ready=1 to the registered outputs.
- Per-edge priority: reset > pcsrc > hazard > imem_ready.
- pc_hold = ~imem_ready | (state==DROP). The fetch stage gives pcsrc priority over pc_hold, so a branch redirect is never blocked.
- RUN:
  - pcsrc: bubble; flush_count++. Next state RUN if imem_ready=1 (response discarded as wrong path), otherwise DROP.
  - else hazard: hold all ID registers; stall_count++; stay RUN. Any response is discarded, because PC is held and the same address is refetched.
  - else imem_ready: capture; stay RUN.
  - else: bubble; go WAIT.
- WAIT: same as RUN, with these differences:
  - No pcsrc and no hazard: imem_ready=1 captures and goes RUN; imem_ready=0 gives a bubble and stays WAIT.
  - hazard with imem_ready=1: go RUN.
- DROP: the outstanding response belongs to a squashed fetch.
  - pcsrc: bubble; flush_count++; stay DROP.
  - hazard: hold; stall_count++.
  - imem_ready=1: discard rdata (no capture; bubble unless hazard); go RUN.
  - imem_ready=0: bubble unless hazard; stay DROP.
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at 2^CNTW-1 (no wrap).
  - pcsrc and hazard in the same cycle: only flush_count increments.
- Bubbles never carry valid=1. A held bubble remains valid=0.

Test Plan:
1. Reset, then imem_ready=1 with if_pc=0x00,0x04,0x08 and rdata=0x20080005,0x20090003,0x01095020 -> one cycle later id_instr follows the same sequence, id_pcplus4=0x04,0x08,0x0C, id_valid=1 each cycle, pc_hold=0.
2. Capture 0x8C080000, then assert hazard for 2 cycles -> id_instr holds 0x8C080000 with valid=1; stall_count=2; fetch resumes and captures the next rdata after hazard drops.
3. imem_ready=0 for 3 cycles, then 1 with rdata=0xAC090004 -> fsm_state=WAIT, id_valid=0, pc_hold=1 throughout; capture on the 4th edge; state RUN.
4. imem_ready=0, then pcsrc=1 for one cycle, then imem_ready=1 with rdata=0xDEADBEEF -> state DROP, bubble, 0xDEADBEEF never appears with valid=1, state RUN; flush_count=1.
5. pcsrc=1 and hazard=1 in the same cycle -> bubble (id_valid=0, id_instr=0); flush_count+1, stall_count unchanged.
6. Preload a counter to 0xFFFE (CNTW=16 bench force), then 3 hazard cycles -> stall_count=0xFFFF, no wrap. Assert reset asynchronously mid-WAIT -> all outputs zero immediately, fsm_state=RUN.

Source files
------------

// File: rtl/pipeline_ifid.sv
// pipeline_ifid: IF/ID pipeline register between instruction fetch and decode.
// Latency: 1 cycle from an accepted imem response (imem_ready=1) to the id_* outputs.
// Backpressure: hazard holds the ID registers; pc_hold stalls fetch while imem is busy or a squashed response is still pending.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   hazard                decode load-use stall: hold the ID registers
//   pcsrc                 branch taken: flush the ID registers
//   if_pc, if_pcplus4     PC and PC+4 of the fetch in flight
//   imem_rdata/ready      instruction memory response and its valid strobe
//   id_instr/pc/pcplus4   registered instruction and PCs presented to decode
//   id_valid              id_instr is a real instruction (0 for bubbles)
//   pc_hold               combinational: fetch must not advance PC
//   fsm_state             0=RUN, 1=WAIT, 2=DROP
//   stall_count           saturating count of hazard-hold cycles
//   flush_count           saturating count of flush cycles

module pipeline_ifid #(
   parameter int                 WIDTH = 32,
   parameter int                 CNTW  = 16,
   parameter logic [WIDTH-1:0]   NOP   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hazard,
   input  logic              pcsrc,
   input  logic [WIDTH-1:0]  if_pc,
   input  logic [WIDTH-1:0]  if_pcplus4,
   input  logic [WIDTH-1:0]  imem_rdata,
   input  logic              imem_ready,
   output logic [WIDTH-1:0]  id_instr,
   output logic [WIDTH-1:0]  id_pc,
   output logic [WIDTH-1:0]  id_pcplus4,
   output logic              id_valid,
   output logic              pc_hold,
   output logic [1:0]        fsm_state,
   output logic [CNTW-1:0]   stall_count,
   output logic [CNTW-1:0]   flush_count
);

   // RUN  : normal streaming, a response is expected every cycle.
   // WAIT : imem went not-ready; the same fetch is still outstanding.
   // DROP : a fetch issued before a taken branch is still outstanding and
   //        its response must be thrown away when it arrives.
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t            state_q,       state_d;
   logic [WIDTH-1:0]  instr_q,       instr_d;
   logic [WIDTH-1:0]  pc_q,          pc_d;
   logic [WIDTH-1:0]  pcplus4_q,     pcplus4_d;
   logic              valid_q,       valid_d;
   logic [CNTW-1:0]   stall_count_q, stall_count_d;
   logic [CNTW-1:0]   flush_count_q, flush_count_d;

   // Per-cycle action decoded by the FSM. Exactly one of bubble/capture/hold
   // applies each cycle; hold is the default (registers keep their value).
   logic              do_bubble;
   logic              do_capture;
   logic              stall_inc;
   logic              flush_inc;

   // ------------------------------------------------------------------
   // Next-state and action decode
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      do_bubble  = 1'b0;
      do_capture = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;

      unique case (state_q)
         ST_RUN, ST_WAIT: begin
            if (pcsrc) begin
               // A response arriving with the flush is wrong-path and is
               // simply dropped; otherwise remember that one is still owed.
               do_bubble = 1'b1;
               flush_inc = 1'b1;
               state_d   = imem_ready ? ST_RUN : ST_DROP;
            end else if (hazard) begin
               // PC is held, so the same address is refetched afterwards;
               // any response this cycle can be discarded.
               stall_inc = 1'b1;
               if (state_q == ST_WAIT && imem_ready) begin
                  state_d = ST_RUN;
               end
            end else if (imem_ready) begin
               do_capture = 1'b1;
               state_d    = ST_RUN;
            end else begin
               do_bubble = 1'b1;
               state_d   = ST_WAIT;
            end
         end

         ST_DROP: begin
            if (pcsrc) begin
               // The squashed fetch is still outstanding: stay here.
               do_bubble = 1'b1;
               flush_inc = 1'b1;
            end else begin
               if (hazard) begin
                  stall_inc = 1'b1;
               end else begin
                  do_bubble = 1'b1;
               end
               // imem_rdata is never captured here; its arrival just ends
               // the drop window.
               if (imem_ready) begin
                  state_d = ST_RUN;
               end
            end
         end

         default: begin
            // Unreachable encoding: recover to RUN with a bubble.
            do_bubble = 1'b1;
            state_d   = ST_RUN;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // ID register next values
   // ------------------------------------------------------------------
   always_comb begin
      instr_d   = instr_q;
      pc_d      = pc_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;

      if (do_capture) begin
         instr_d   = imem_rdata;
         pc_d      = if_pc;
         pcplus4_d = if_pcplus4;
         valid_d   = 1'b1;
      end else if (do_bubble) begin
         // Bubbles keep the PCs so decode still sees a sensible address.
         instr_d = NOP;
         valid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Saturating event counters
   // ------------------------------------------------------------------
   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;

      if (stall_inc && (stall_count_q != {CNTW{1'b1}})) begin
         stall_count_d = stall_count_q + CNTW'(1);
      end
      if (flush_inc && (flush_count_q != {CNTW{1'b1}})) begin
         flush_count_d = flush_count_q + CNTW'(1);
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_RUN;
         instr_q       <= NOP;
         pc_q          <= '0;
         pcplus4_q     <= '0;
         valid_q       <= 1'b0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         pc_q          <= pc_d;
         pcplus4_q     <= pcplus4_d;
         valid_q       <= valid_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // pcsrc is not folded in here: the fetch stage lets a redirect win over
   // pc_hold, so a branch is never blocked by an outstanding response.
   assign pc_hold     = ~imem_ready | (state_q == ST_DROP);

   assign id_instr    = instr_q;
   assign id_pc       = pc_q;
   assign id_pcplus4  = pcplus4_q;
   assign id_valid    = valid_q;
   assign fsm_state   = state_q;
   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule
